unified_mem_arbiter: RTL and testbench

- Shares one single-port memory between the pipeline's instruction-fetch port and its data (load/store) port, so the SOPC can run from a unified memory instead of separate ROM and RAM.
- Sits between the pipeline CPU's fetch/data interfaces and the memory model.
- Serialises accesses through a small state machine with a fixed memory latency.
- Returns a one-cycle acknowledge with registered read data; the CPU stalls until it sees the acknowledge.

---
 rtl/unified_mem_arbiter_pkg.sv | 28 ++
 rtl/unified_mem_arbiter_if.sv | 57 +++++
 rtl/unified_mem_arbiter_rr_picker2.sv | 32 +++
 rtl/unified_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter_pkg
// Shared types and constants for the unified instruction/data memory arbiter.
//   state_e  : arbiter FSM encoding (IDLE / ACCESS / DONE, 2 bits)
//   grant_e  : which CPU port owns the memory (GRANT_INST = 0, GRANT_DATA = 1)
//   DEF_*    : default widths and memory latency
// -----------------------------------------------------------------------------
package unified_mem_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_MEM_LATENCY = 2;

  // Latency counter width; covers MemLatency values 1..15.
  localparam int CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } grant_e;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter_if
// Bundles the CPU fetch port, the CPU data port and the single-port memory bus
// seen by the arbiter.
//   master : the CPU + memory side (drives requests and mem_rdata)
//   slave  : the arbiter (drives acks, read data and the mem_* request)
//
// Handshake: a port raises *_req with its address/controls and holds them
// stable until it sees *_ack. *_ack is a one-cycle pulse and the matching
// *_rdata is valid in that same cycle. In the cycle after *_ack the port either
// drops *_req or presents a new request. The memory samples mem_* whenever
// mem_ce is high and returns mem_rdata combinationally from mem_addr.
// -----------------------------------------------------------------------------
interface unified_mem_arbiter_if
  import unified_mem_arbiter_pkg::*;
#(
  parameter int AddrWidth = DEF_ADDR_WIDTH,
  parameter int DataWidth = DEF_DATA_WIDTH
);

  logic                 inst_req;
  logic [AddrWidth-1:0] inst_addr;
  logic                 inst_ack;
  logic [DataWidth-1:0] inst_rdata;

  logic                 data_req;
  logic                 data_we;
  logic [AddrWidth-1:0] data_addr;
  logic [3:0]           data_byte_slct;
  logic [DataWidth-1:0] data_wdata;
  logic                 data_ack;
  logic [DataWidth-1:0] data_rdata;

  logic                 mem_ce;
  logic                 mem_we;
  logic [AddrWidth-1:0] mem_addr;
  logic [3:0]           mem_byte_slct;
  logic [DataWidth-1:0] mem_wdata;
  logic [DataWidth-1:0] mem_rdata;

  modport master (
    output inst_req, inst_addr,
    output data_req, data_we, data_addr, data_byte_slct, data_wdata,
    output mem_rdata,
    input  inst_ack, inst_rdata, data_ack, data_rdata,
    input  mem_ce, mem_we, mem_addr, mem_byte_slct, mem_wdata
  );

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_we, data_addr, data_byte_slct, data_wdata,
    input  mem_rdata,
    output inst_ack, inst_rdata, data_ack, data_rdata,
    output mem_ce, mem_we, mem_addr, mem_byte_slct, mem_wdata
  );

endinterface

// File: rtl/unified_mem_arbiter_rr_picker2.sv
// -----------------------------------------------------------------------------
// rr_picker2
// Two-way round-robin picker, purely combinational.
//   req_inst_i    : fetch port requesting
//   req_data_i    : data port requesting
//   last_grant_i  : port served most recently
//   grant_valid_o : at least one request present
//   grant_o       : winner (valid only when grant_valid_o is high)
// A lone requester always wins; on a tie the port that was not served last
// wins.
// -----------------------------------------------------------------------------
module rr_picker2
  import unified_mem_arbiter_pkg::*;
(
  input  logic   req_inst_i,
  input  logic   req_data_i,
  input  grant_e last_grant_i,
  output logic   grant_valid_o,
  output grant_e grant_o
);

  always_comb begin
    grant_valid_o = req_inst_i | req_data_i;
    grant_o       = GRANT_INST;
    if (req_inst_i && req_data_i) begin
      grant_o = (last_grant_i == GRANT_INST) ? GRANT_DATA : GRANT_INST;
    end else if (req_data_i) begin
      grant_o = GRANT_DATA;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
// Shares one single-port memory between the CPU fetch port and the CPU
// load/store port. Accesses are serialised: IDLE picks a winner and latches its
// request, ACCESS holds the memory request for MemLatency cycles and captures
// read data on the last one, DONE pulses the winner's ack for one cycle.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   bus     : fetch / data / memory signals (slave modport)
//   state_o : current FSM state, for observation
// Parameters: AddrWidth, DataWidth, MemLatency (1..15).
// All outputs are registers or decodes of registered state; no request input
// reaches an ack or mem_* output combinationally.
// -----------------------------------------------------------------------------
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int AddrWidth  = DEF_ADDR_WIDTH,
  parameter int DataWidth  = DEF_DATA_WIDTH,
  parameter int MemLatency = DEF_MEM_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  unified_mem_arbiter_if.slave  bus,
  output state_e                state_o
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  grant_e               grant_q, grant_d;
  grant_e               last_grant_q, last_grant_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 we_q, we_d;
  logic [3:0]           byte_slct_q, byte_slct_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [DataWidth-1:0] inst_rdata_q, inst_rdata_d;
  logic [DataWidth-1:0] data_rdata_q, data_rdata_d;

  logic                 pick_valid;
  grant_e               pick_grant;

  rr_picker2 u_picker (
    .req_inst_i    (bus.inst_req),
    .req_data_i    (bus.data_req),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (pick_valid),
    .grant_o       (pick_grant)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    byte_slct_d  = byte_slct_q;
    wdata_d      = wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_ACCESS;
          cnt_d   = CNT_WIDTH'(MemLatency);
          grant_d = pick_grant;
          if (pick_grant == GRANT_DATA) begin
            addr_d      = bus.data_addr;
            we_d        = bus.data_we;
            byte_slct_d = bus.data_byte_slct;
            wdata_d     = bus.data_wdata;
          end else begin
            // A fetch reads a whole word and never writes.
            addr_d      = bus.inst_addr;
            we_d        = 1'b0;
            byte_slct_d = 4'b1111;
            wdata_d     = '0;
          end
        end
      end

      ST_ACCESS: begin
        cnt_d = cnt_q - CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(1)) begin
          state_d = ST_DONE;
          // Stores leave the data read register untouched.
          if (!we_q) begin
            if (grant_q == GRANT_DATA) data_rdata_d = bus.mem_rdata;
            else                       inst_rdata_d = bus.mem_rdata;
          end
        end
      end

      ST_DONE: begin
        // Always pass through IDLE so a request still held here cannot be
        // served twice.
        state_d      = ST_IDLE;
        last_grant_d = grant_q;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      grant_q      <= GRANT_INST;
      last_grant_q <= GRANT_INST;
      addr_q       <= '0;
      we_q         <= 1'b0;
      byte_slct_q  <= '0;
      wdata_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      byte_slct_q  <= byte_slct_d;
      wdata_q      <= wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  logic in_access;
  logic in_done;
  assign in_access = (state_q == ST_ACCESS);
  assign in_done   = (state_q == ST_DONE);

  // Memory bus is driven only while an access is in flight, zero otherwise.
  assign bus.mem_ce        = in_access;
  assign bus.mem_we        = in_access & we_q;
  assign bus.mem_addr      = in_access ? addr_q      : '0;
  assign bus.mem_byte_slct = in_access ? byte_slct_q : '0;
  assign bus.mem_wdata     = in_access ? wdata_q     : '0;

  assign bus.inst_ack   = in_done & (grant_q == GRANT_INST);
  assign bus.data_ack   = in_done & (grant_q == GRANT_DATA);
  assign bus.inst_rdata = inst_rdata_q;
  assign bus.data_rdata = data_rdata_q;

  assign state_o = state_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;
  import unified_mem_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  int          n_checks;
  int          n_errors;
  logic [31:0] exp_q[$];
  logic [31:0] got;
  logic [31:0] mem2 [0:255];
  logic [31:0] mem1 [0:255];
  logic [31:0] l1_words [0:2];
  int          l1_idx;
  state_e      state2;
  state_e      state1;

  unified_mem_arbiter_if #(.AddrWidth(32), .DataWidth(32)) bus2 ();
  unified_mem_arbiter_if #(.AddrWidth(32), .DataWidth(32)) bus1 ();

  unified_mem_arbiter #(.AddrWidth(32), .DataWidth(32), .MemLatency(2)) dut2 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus2.slave),
    .state_o (state2)
  );

  unified_mem_arbiter #(.AddrWidth(32), .DataWidth(32), .MemLatency(1)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus1.slave),
    .state_o (state1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory models: combinational read, byte-enabled write at the clock edge
  assign bus2.mem_rdata = mem2[bus2.mem_addr[9:2]];
  assign bus1.mem_rdata = mem1[bus1.mem_addr[9:2]];

  always @(posedge clk) begin
    if (bus2.mem_ce && bus2.mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus2.mem_byte_slct[b]) mem2[bus2.mem_addr[9:2]][8*b +: 8] <= bus2.mem_wdata[8*b +: 8];
      end
    end
    if (bus1.mem_ce && bus1.mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus1.mem_byte_slct[b]) mem1[bus1.mem_addr[9:2]][8*b +: 8] <= bus1.mem_wdata[8*b +: 8];
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    for (int i = 0; i < 256; i++) begin
      mem2[i] = 32'h0;
      mem1[i] = 32'h0;
    end
    mem2[4]  = 32'h2401_0005;  // 0x10
    mem2[5]  = 32'h1111_2222;  // 0x14
    mem2[6]  = 32'h3333_4444;  // 0x18
    mem2[8]  = 32'h0000_ABCD;  // 0x20
    mem1[0]  = 32'hA0A0_0001;
    mem1[1]  = 32'hA0A0_0002;
    mem1[2]  = 32'hA0A0_0003;
    l1_words[0] = 32'hA0A0_0001;
    l1_words[1] = 32'hA0A0_0002;
    l1_words[2] = 32'hA0A0_0003;

    bus1.inst_req = 1'b0; bus1.inst_addr = '0;
    bus1.data_req = 1'b0; bus1.data_we = 1'b0; bus1.data_addr = '0;
    bus1.data_byte_slct = 4'hF; bus1.data_wdata = '0;

    // reset held for two edges with both requests high
    bus2.inst_req = 1'b1; bus2.inst_addr = 32'h14;
    bus2.data_req = 1'b1; bus2.data_we = 1'b0; bus2.data_addr = 32'h20;
    bus2.data_byte_slct = 4'hF; bus2.data_wdata = '0;
    tick();
    tick();
    check_eq("rst_state", 32'(state2), 32'(ST_IDLE));
    check_eq("rst_inst_ack", 32'(bus2.inst_ack), 32'd0);
    check_eq("rst_data_ack", 32'(bus2.data_ack), 32'd0);
    check_eq("rst_inst_rdata", bus2.inst_rdata, 32'h0);
    check_eq("rst_data_rdata", bus2.data_rdata, 32'h0);
    check_eq("rst_mem_ce", 32'(bus2.mem_ce), 32'd0);
    check_eq("rst_mem_we", 32'(bus2.mem_we), 32'd0);
    check_eq("rst_mem_addr", bus2.mem_addr, 32'h0);
    check_eq("rst_mem_byte_slct", 32'(bus2.mem_byte_slct), 32'd0);
    check_eq("rst_mem_wdata", bus2.mem_wdata, 32'h0);

    // tie right after reset: D at 3, I at 7, D at 11, I at 15 (cycle*2 + port)
    exp_q.push_back(32'(3 * 2 + 1));
    exp_q.push_back(32'(7 * 2 + 0));
    exp_q.push_back(32'(11 * 2 + 1));
    exp_q.push_back(32'(15 * 2 + 0));
    rst = 1'b0;  // cycle 0
    for (int cyc = 1; cyc <= 15; cyc++) begin
      tick();
      if (bus2.inst_ack || bus2.data_ack) begin
        got = 32'(cyc * 2 + (bus2.data_ack ? 1 : 0));
        if (exp_q.size() == 0) check_eq("tie_extra_ack", got, 32'hFFFF_FFFF);
        else check_eq("tie_ack_order", got, exp_q.pop_front());
      end
      if (cyc == 1) begin
        check_eq("tie_c1_mem_ce", 32'(bus2.mem_ce), 32'd1);
        check_eq("tie_c1_mem_addr", bus2.mem_addr, 32'h20);
      end
      if (cyc == 3) check_eq("tie_c3_data_rdata", bus2.data_rdata, 32'h0000_ABCD);
      if (cyc == 4) check_eq("tie_c4_mem_ce", 32'(bus2.mem_ce), 32'd0);
      if (cyc == 5) check_eq("tie_c5_mem_addr", bus2.mem_addr, 32'h14);
      if (cyc == 7) check_eq("tie_c7_inst_rdata", bus2.inst_rdata, 32'h1111_2222);
    end
    check_eq("tie_acks_left", 32'(exp_q.size()), 32'd0);
    bus2.inst_req = 1'b0;
    bus2.data_req = 1'b0;
    tick();
    check_eq("idle_mem_ce", 32'(bus2.mem_ce), 32'd0);

    // single fetch from 0x10
    bus2.inst_req = 1'b1; bus2.inst_addr = 32'h10;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      tick();
      check_eq("fetch_no_data_ack", 32'(bus2.data_ack), 32'd0);
      if (cyc <= 2) begin
        check_eq("fetch_mem_ce", 32'(bus2.mem_ce), 32'd1);
        check_eq("fetch_mem_addr", bus2.mem_addr, 32'h10);
        check_eq("fetch_mem_we", 32'(bus2.mem_we), 32'd0);
        check_eq("fetch_early_ack", 32'(bus2.inst_ack), 32'd0);
      end else begin
        check_eq("fetch_ack", 32'(bus2.inst_ack), 32'd1);
        check_eq("fetch_ack_mem_ce", 32'(bus2.mem_ce), 32'd0);
        check_eq("fetch_rdata", bus2.inst_rdata, 32'h2401_0005);
      end
    end
    bus2.inst_req = 1'b0;
    tick();

    // byte store to 0x40 then load back
    bus2.data_req = 1'b1; bus2.data_we = 1'b1; bus2.data_addr = 32'h40;
    bus2.data_byte_slct = 4'b0011; bus2.data_wdata = 32'hDEAD_BEEF;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      tick();
      check_eq("st_mem_we", 32'(bus2.mem_we), 32'((cyc == 1) || (cyc == 2)));
      if (cyc <= 2) begin
        check_eq("st_byte_slct", 32'(bus2.mem_byte_slct), 32'b0011);
        check_eq("st_wdata", bus2.mem_wdata, 32'hDEAD_BEEF);
      end
      if (cyc == 3) begin
        check_eq("st_ack", 32'(bus2.data_ack), 32'd1);
        check_eq("st_keeps_rdata", bus2.data_rdata, 32'h0000_ABCD);
        bus2.data_we = 1'b0; bus2.data_byte_slct = 4'hF; bus2.data_wdata = '0;
      end
      if (cyc == 6) check_eq("ld_early_ack", 32'(bus2.data_ack), 32'd0);
      if (cyc == 7) begin
        check_eq("ld_ack", 32'(bus2.data_ack), 32'd1);
        check_eq("ld_rdata", bus2.data_rdata, 32'h0000_BEEF);
        bus2.data_req = 1'b0;
      end
    end
    tick();

    // reset during the first access cycle of a fetch
    bus2.inst_req = 1'b1; bus2.inst_addr = 32'h18;
    tick();
    check_eq("rmid_c1_mem_ce", 32'(bus2.mem_ce), 32'd1);
    rst = 1'b1;
    tick();
    check_eq("rmid_mem_ce", 32'(bus2.mem_ce), 32'd0);
    check_eq("rmid_no_ack", 32'(bus2.inst_ack), 32'd0);
    check_eq("rmid_rdata_clr", bus2.inst_rdata, 32'h0);
    check_eq("rmid_state", 32'(state2), 32'(ST_IDLE));
    rst = 1'b0;
    for (int cyc = 3; cyc <= 5; cyc++) begin
      tick();
      check_eq("rmid_ack", 32'(bus2.inst_ack), 32'(cyc == 5));
      if (cyc < 5) check_eq("rmid_re_mem_ce", 32'(bus2.mem_ce), 32'd1);
      else check_eq("rmid_rdata", bus2.inst_rdata, 32'h3333_4444);
    end
    bus2.inst_req = 1'b0;
    tick();

    // MemLatency = 1: back-to-back loads acked at 2, 5, 8
    l1_idx = 0;
    bus1.data_req = 1'b1; bus1.data_we = 1'b0; bus1.data_addr = 32'h0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      tick();
      check_eq("l1_mem_ce", 32'(bus1.mem_ce), 32'((cyc == 1) || (cyc == 4) || (cyc == 7)));
      check_eq("l1_data_ack", 32'(bus1.data_ack), 32'((cyc == 2) || (cyc == 5) || (cyc == 8)));
      if (bus1.data_ack && (l1_idx < 3)) begin
        check_eq("l1_rdata", bus1.data_rdata, l1_words[l1_idx]);
        l1_idx++;
        if (l1_idx < 3) bus1.data_addr = 32'(l1_idx * 4);
        else bus1.data_req = 1'b0;
      end
    end
    check_eq("l1_loads_done", 32'(l1_idx), 32'd3);
    check_eq("l1_no_inst_ack", 32'(bus1.inst_ack), 32'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
